sm3_expnd_core: RTL and testbench

- Message-expansion stage directly downstream of the SM3 padding stage.
- Accepts the padded message as 512-bit blocks, in PAD_DW-bit beats under a valid/enable handshake.
- Generates the 64 round word pairs (Wj, W'j) per block. Streams them with a round index, a first-round flag and a last-round flag to the compression stage under valid/enable back-pressure.
- The expansion is a 16-word sliding window: one new W word is computed per accepted output round.

---
 rtl/sm3_expnd_core.sv | 134 +++++++++++++
 tb/tb_sm3_expnd_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_expnd_core.sv
// rtl/sm3_expnd_core.sv - SM3 message expansion: 512-bit block in, 64 (Wj, W'j) round pairs out
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pad_otpt_d_i          padded message beat (PAD_DW bits, high word earliest)
//   pad_otpt_vld_i        beat valid
//   pad_otpt_lst_i        beat belongs to the final block of the message
//   pad_otpt_ena_o        stage can accept a beat (low while rounds stream)
//   expnd_otpt_w_o        Wj
//   expnd_otpt_wp_o       W'j = Wj ^ Wj+4
//   expnd_otpt_idx_o      round index j
//   expnd_otpt_fst_o      j == 0
//   expnd_otpt_lst_o      j == 63 of the final block
//   expnd_otpt_vld_o      round outputs valid
//   expnd_otpt_ena_i      downstream consumes the current round
module sm3_expnd_core #(
  parameter int PAD_DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PAD_DW-1:0] pad_otpt_d_i,
  input  logic              pad_otpt_vld_i,
  input  logic              pad_otpt_lst_i,
  output logic              pad_otpt_ena_o,
  output logic [31:0]       expnd_otpt_w_o,
  output logic [31:0]       expnd_otpt_wp_o,
  output logic [5:0]        expnd_otpt_idx_o,
  output logic              expnd_otpt_fst_o,
  output logic              expnd_otpt_lst_o,
  output logic              expnd_otpt_vld_o,
  input  logic              expnd_otpt_ena_i
);

  localparam int WPB = PAD_DW / 32;   // words per beat
  localparam int BPB = 512 / PAD_DW;  // beats per block

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  beat_q, beat_d;
  logic [5:0]  rnd_q, rnd_d;
  logic        lst_q, lst_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];

  logic        beat_acc;
  logic        rnd_acc;
  logic [31:0] w_new;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  assign pad_otpt_ena_o   = (state_q != ST_ROUND);
  assign expnd_otpt_vld_o = (state_q == ST_ROUND);

  // Outputs are forced to zero outside ROUND so idle/load cycles present a clean bus.
  assign expnd_otpt_w_o   = expnd_otpt_vld_o ? win_q[0] : 32'd0;
  assign expnd_otpt_wp_o  = expnd_otpt_vld_o ? (win_q[0] ^ win_q[4]) : 32'd0;
  assign expnd_otpt_idx_o = expnd_otpt_vld_o ? rnd_q : 6'd0;
  assign expnd_otpt_fst_o = expnd_otpt_vld_o && (rnd_q == 6'd0);
  assign expnd_otpt_lst_o = expnd_otpt_vld_o && lst_q && (rnd_q == 6'd63);

  assign beat_acc = pad_otpt_vld_i && pad_otpt_ena_o;
  assign rnd_acc  = expnd_otpt_vld_o && expnd_otpt_ena_i;

  // Window holds Wj..Wj+15, so the new word is Wj+16.
  assign w_new = p1(win_q[0] ^ win_q[7] ^ rotl(win_q[13], 15)) ^ rotl(win_q[3], 7) ^ win_q[10];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rnd_d   = rnd_q;
    lst_d   = lst_q;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (beat_acc) begin
          for (int i = 0; i < 16 - WPB; i++) win_d[i] = win_q[i + WPB];
          for (int k = 0; k < WPB; k++) begin
            win_d[16 - WPB + k] = pad_otpt_d_i[PAD_DW - 1 - 32 * k -: 32];
          end
          beat_d = beat_q + 5'd1;
          lst_d  = lst_q | pad_otpt_lst_i;
          if (beat_q == 5'(BPB - 1)) begin
            state_d = ST_ROUND;
            rnd_d   = 6'd0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_ROUND: begin
        if (rnd_acc) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
          win_d[15] = w_new;
          rnd_d     = rnd_q + 6'd1;
          if (rnd_q == 6'd63) begin
            state_d = ST_IDLE;
            lst_d   = 1'b0;
            beat_d  = 5'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 5'd0;
      rnd_q   <= 6'd0;
      lst_q   <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rnd_q   <= rnd_d;
      lst_q   <= lst_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: tb/tb_sm3_expnd_core.sv
// tb/tb_sm3_expnd_core.sv - scoreboard bench for sm3_expnd_core, 32- and 64-bit beat instances
module tb_sm3_expnd_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] d32;
  logic        v32, l32, e32;
  logic [63:0] d64;
  logic        v64, l64, e64;
  logic        dn_ena;
  logic [31:0] w32, wp32, w64, wp64;
  logic [5:0]  i32, i64;
  logic        f32, f64, ls32, ls64, vo32, vo64;

  sm3_expnd_core #(.PAD_DW(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .pad_otpt_d_i(d32), .pad_otpt_vld_i(v32), .pad_otpt_lst_i(l32), .pad_otpt_ena_o(e32),
    .expnd_otpt_w_o(w32), .expnd_otpt_wp_o(wp32), .expnd_otpt_idx_o(i32),
    .expnd_otpt_fst_o(f32), .expnd_otpt_lst_o(ls32), .expnd_otpt_vld_o(vo32),
    .expnd_otpt_ena_i(dn_ena)
  );

  sm3_expnd_core #(.PAD_DW(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .pad_otpt_d_i(d64), .pad_otpt_vld_i(v64), .pad_otpt_lst_i(l64), .pad_otpt_ena_o(e64),
    .expnd_otpt_w_o(w64), .expnd_otpt_wp_o(wp64), .expnd_otpt_idx_o(i64),
    .expnd_otpt_fst_o(f64), .expnd_otpt_lst_o(ls64), .expnd_otpt_vld_o(vo64),
    .expnd_otpt_ena_i(dn_ena)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] wp;
    logic [5:0]  idx;
    logic        fst;
    logic        lst;
  } rnd_t;

  rnd_t        q32[$];
  rnd_t        q64[$];
  rnd_t        blk[64];
  logic [31:0] msg[16];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_cons32 = -10;
  int          dn_mode = 0;
  int          stall_cnt = 0;
  bit          stalled = 0;
  bit          abc_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // Reference: full W[0..67] array from the SM3 recurrence, then the 64 round records.
  task automatic build(input bit last);
    logic [31:0] ww[68];
    for (int j = 0; j < 16; j++) ww[j] = msg[j];
    for (int j = 16; j < 68; j++)
      ww[j] = p1(ww[j-16] ^ ww[j-9] ^ rotl(ww[j-3], 15)) ^ rotl(ww[j-13], 7) ^ ww[j-6];
    for (int j = 0; j < 64; j++) begin
      blk[j].w   = ww[j];
      blk[j].wp  = ww[j] ^ ww[j+4];
      blk[j].idx = 6'(j);
      blk[j].fst = (j == 0);
      blk[j].lst = last && (j == 63);
    end
  endtask

  task automatic push(input bit to32, input bit to64);
    for (int j = 0; j < 64; j++) begin
      if (to32) q32.push_back(blk[j]);
      if (to64) q64.push_back(blk[j]);
    end
  endtask

  task automatic set_abc();
    for (int j = 0; j < 16; j++) msg[j] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic set_rand();
    for (int j = 0; j < 16; j++) msg[j] = $urandom;
  endtask

  task automatic send(input bit wide, input bit last, input int maxgap, input bit b2b);
    int nb;
    nb = wide ? 8 : 16;
    for (int b = 0; b < nb; b++) begin
      bit acc;
      int n;
      int acc_cyc;
      acc = 0;
      n = 0;
      acc_cyc = 0;
      repeat ($urandom_range(maxgap, 0)) begin
        @(negedge clk);
        if (wide) v64 = 0; else v32 = 0;
      end
      do begin
        @(negedge clk);
        if (wide) begin
          v64 = 1; d64 = {msg[2*b], msg[2*b+1]}; l64 = last && (b == nb - 1); acc = e64;
        end else begin
          v32 = 1; d32 = msg[b]; l32 = last && (b == nb - 1); acc = e32;
        end
        acc_cyc = cyc;
        n++;
        @(posedge clk);
      end while (!acc && n < 1000);
      if (!acc) chk("beat_accept_timeout", 80'(acc), 80'(1));
      if (b == 0 && b2b) chk("b2b_first_beat_cycle", 80'(acc_cyc), 80'(last_cons32 + 1));
    end
    @(negedge clk);
    if (wide) begin
      v64 = 0; l64 = 0;
      chk("latency64_vld_idx", {vo64, i64}, {1'b1, 6'd0});
    end else begin
      v32 = 0; l32 = 0;
      chk("latency32_vld_idx", {vo32, i32}, {1'b1, 6'd0});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q32_empty", 80'(q32.size()), 80'(0));
    chk("drain_q64_empty", 80'(q64.size()), 80'(0));
    @(negedge clk);
    chk("end_block_vld_low", {vo32, vo64}, 2'b00);
  endtask

  // Downstream enable: 0 = always on, 1 = toggle plus one 10-cycle stall at idx 30, else random.
  initial begin
    dn_ena = 1;
    forever begin
      @(posedge clk);
      #1;
      case (dn_mode)
        0: dn_ena = 1;
        1: begin
          if (stall_cnt > 0) begin
            dn_ena = 0;
            stall_cnt--;
          end else if (vo32 && i32 == 6'd30 && !stalled) begin
            stalled = 1;
            dn_ena = 0;
            stall_cnt = 9;
          end else begin
            dn_ena = !dn_ena;
          end
        end
        default: dn_ena = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Monitor: pops on every consumed round, checks hold on stalled rounds.
  rnd_t a32, a64, h32, h64;
  bit   hv32 = 0, hv64 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hv32 = 0;
      hv64 = 0;
    end else begin
      a32 = '{w: w32, wp: wp32, idx: i32, fst: f32, lst: ls32};
      a64 = '{w: w64, wp: wp64, idx: i64, fst: f64, lst: ls64};
      if (vo32) begin
        chk("pad_ena_low_in_round32", 80'(e32), 80'(0));
        if (hv32) chk("stall_hold32", 80'(a32), 80'(h32));
        if (dn_ena) begin
          if (q32.size() == 0) chk("unexpected_round32", 80'(a32), 80'(0));
          else chk("round32", 80'(a32), 80'(q32.pop_front()));
          if (abc_on && i32 == 6'd0)  chk("abc32_w0", 80'(w32), 80'(32'h61626380));
          if (abc_on && i32 == 6'd16) chk("abc32_w16", 80'(w32), 80'(32'h9092e200));
          if (abc_on && i32 == 6'd18) chk("abc32_w18", 80'(w32), 80'(32'h000c0606));
          if (i32 == 6'd63) last_cons32 = cyc;
          hv32 = 0;
        end else begin
          h32 = a32;
          hv32 = 1;
        end
      end else begin
        hv32 = 0;
      end
      if (vo64) begin
        chk("pad_ena_low_in_round64", 80'(e64), 80'(0));
        if (hv64) chk("stall_hold64", 80'(a64), 80'(h64));
        if (dn_ena) begin
          if (q64.size() == 0) chk("unexpected_round64", 80'(a64), 80'(0));
          else chk("round64", 80'(a64), 80'(q64.pop_front()));
          if (abc_on && i64 == 6'd16) chk("abc64_w16", 80'(w64), 80'(32'h9092e200));
          hv64 = 0;
        end else begin
          h64 = a64;
          hv64 = 1;
        end
      end else begin
        hv64 = 0;
      end
    end
  end

  initial begin
    int n;
    bit lst;
    rst_n = 0;
    v32 = 0; d32 = '0; l32 = 0;
    v64 = 0; d64 = '0; l64 = 0;
    #1;
    chk("reset_pad_ena", {e32, e64}, 2'b11);
    chk("reset_out32", {vo32, w32, wp32, i32, f32, ls32}, 80'(0));
    chk("reset_out64", {vo64, w64, wp64, i64, f64, ls64}, 80'(0));
    repeat (3) @(negedge clk);
    rst_n = 1;

    // "abc" on both beat widths, downstream always ready
    set_abc();
    build(1);
    push(1, 1);
    abc_on = 1;
    fork
      send(0, 1, 0, 0);
      send(1, 1, 0, 0);
    join
    drain();
    abc_on = 0;

    // toggling downstream enable with a long stall at idx 30
    dn_mode = 1;
    build(1);
    push(1, 0);
    abc_on = 1;
    send(0, 1, 0, 0);
    drain();
    abc_on = 0;
    chk("stall_seen", 80'(stalled), 80'(1));

    // two back-to-back blocks, lst only on the second
    dn_mode = 2;
    set_rand();
    build(0);
    push(1, 0);
    send(0, 0, 0, 0);
    set_rand();
    build(1);
    push(1, 0);
    send(0, 1, 0, 1);
    drain();

    // random blocks with upstream gaps on both widths
    for (int k = 0; k < 3; k++) begin
      set_rand();
      lst = 1'($urandom_range(1, 0));
      build(lst);
      push(1, 1);
      fork
        send(0, lst, 3, 0);
        send(1, lst, 3, 0);
      join
    end
    drain();

    // asynchronous reset in the middle of the round stream
    dn_mode = 0;
    set_abc();
    build(1);
    push(1, 0);
    send(0, 1, 0, 0);
    n = 0;
    while (!(vo32 && i32 == 6'd20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx20", {vo32, i32}, {1'b1, 6'd20});
    #2;
    rst_n = 0;
    q32.delete();
    #1;
    chk("async_reset_vld_ena", {vo32, e32}, 2'b01);
    @(negedge clk);
    chk("reset_next_cycle_vld_ena", {vo32, e32}, 2'b01);
    rst_n = 1;
    abc_on = 1;
    push(1, 0);
    send(0, 1, 0, 0);
    drain();
    abc_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
